// File: rtl/ex_branch_pkg.sv
// rtl/ex_branch_pkg.sv - shared types, op encodings and FSM states for the branch unit
package ex_branch_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_TAG_W  = 5;
  localparam int DEF_OP_W   = 6;

  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_WORD_W-1:0] word_t;
  typedef logic [DEF_TAG_W-1:0]  regtag_t;
  typedef logic [DEF_OP_W-1:0]   sinst_t;

  // A tag of zero means the operand data in the RS entry is final
  localparam regtag_t TAG_UNLOCKED = '0;

  localparam sinst_t OP_BEQ  = 6'd1;
  localparam sinst_t OP_BNE  = 6'd2;
  localparam sinst_t OP_BLT  = 6'd3;
  localparam sinst_t OP_BGE  = 6'd4;
  localparam sinst_t OP_BLTU = 6'd5;
  localparam sinst_t OP_BGEU = 6'd6;
  localparam sinst_t OP_JAL  = 6'd7;
  localparam sinst_t OP_JALR = 6'd8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_RESP  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ex_branch_cmp.sv
// rtl/ex_branch_cmp.sv - combinational branch condition, target and link evaluator
module branch_cmp
  import ex_branch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] pc,
  input  logic [WORD_W-1:0] offset,
  input  logic [WORD_W-1:0] datax,
  input  logic [WORD_W-1:0] datay,
  output logic              taken,
  output logic [ADDR_W-1:0] target,
  output logic [WORD_W-1:0] link,
  output logic              is_link
);

  logic              w_eq;
  logic              w_lt;
  logic              w_ltu;
  logic [WORD_W-1:0] w_jalr_sum;

  assign w_eq       = (datax == datay);
  assign w_lt       = ($signed(datax) < $signed(datay));
  assign w_ltu      = (datax < datay);
  assign w_jalr_sum = datax + offset;
  assign link       = WORD_W'(pc) + WORD_W'(4);

  always_comb begin
    taken   = 1'b0;
    is_link = 1'b0;
    target  = pc + ADDR_W'(offset);
    case (op)
      OP_BEQ:  taken = w_eq;
      OP_BNE:  taken = ~w_eq;
      OP_BLT:  taken = w_lt;
      OP_BGE:  taken = ~w_lt;
      OP_BLTU: taken = w_ltu;
      OP_BGEU: taken = ~w_ltu;
      OP_JAL: begin
        taken   = 1'b1;
        is_link = 1'b1;
      end
      OP_JALR: begin
        taken   = 1'b1;
        is_link = 1'b1;
        target  = ADDR_W'(w_jalr_sum) & ~ADDR_W'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_branch.sv
// rtl/ex_branch.sv - branch execution unit: accepts an RS entry, resolves it and
// issues redirect, link broadcast and a flush window before releasing the entry.
module ex_branch
  import ex_branch_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int WORD_W       = DEF_WORD_W,
  parameter int TAG_W        = DEF_TAG_W,
  parameter int OP_W         = DEF_OP_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc,
  input  logic [WORD_W-1:0] offset,
  input  logic              busy_in,
  input  logic [OP_W-1:0]   op,
  input  logic [TAG_W-1:0]  tagx,
  input  logic [TAG_W-1:0]  tagy,
  input  logic [WORD_W-1:0] datax,
  input  logic [WORD_W-1:0] datay,
  output logic              busy_branch,
  output logic              jump_en,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              flush,
  output logic              link_en,
  output logic [WORD_W-1:0] link_data,
  output logic              misalign
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [WORD_W-1:0] r_offset;
  logic [OP_W-1:0]   r_op;
  logic [WORD_W-1:0] r_datax;
  logic [WORD_W-1:0] r_datay;
  logic              r_taken;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_jump_en;
  logic [ADDR_W-1:0] r_jump_addr;
  logic              r_flush;
  logic              r_link_en;
  logic [WORD_W-1:0] r_link_data;
  logic              r_misalign;

  logic              w_taken;
  logic [ADDR_W-1:0] w_target;
  logic [WORD_W-1:0] w_link;
  logic              w_is_link;
  logic              w_accept;

  branch_cmp #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W),
    .OP_W   (OP_W)
  ) u_cmp (
    .op      (r_op),
    .pc      (r_pc),
    .offset  (r_offset),
    .datax   (r_datax),
    .datay   (r_datay),
    .taken   (w_taken),
    .target  (w_target),
    .link    (w_link),
    .is_link (w_is_link)
  );

  assign w_accept = busy_in && (tagx == TAG_W'(TAG_UNLOCKED)) && (tagy == TAG_W'(TAG_UNLOCKED));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_offset    <= '0;
      r_op        <= '0;
      r_datax     <= '0;
      r_datay     <= '0;
      r_taken     <= 1'b0;
      r_cnt       <= '0;
      r_jump_en   <= 1'b0;
      r_jump_addr <= '0;
      r_flush     <= 1'b0;
      r_link_en   <= 1'b0;
      r_link_data <= '0;
      r_misalign  <= 1'b0;
    end else if (rdy) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pc     <= pc;
            r_offset <= offset;
            r_op     <= op;
            r_datax  <= datax;
            r_datay  <= datay;
            r_state  <= S_EXEC;
          end
        end
        // Outputs are loaded here so they are visible for exactly the RESP cycle
        S_EXEC: begin
          r_taken     <= w_taken;
          r_jump_en   <= w_taken;
          r_jump_addr <= w_target;
          r_link_en   <= w_is_link;
          r_link_data <= w_link;
          r_misalign  <= w_taken & w_target[1];
          r_state     <= S_RESP;
        end
        S_RESP: begin
          r_jump_en  <= 1'b0;
          r_link_en  <= 1'b0;
          r_misalign <= 1'b0;
          if (r_taken) begin
            r_flush <= 1'b1;
            r_cnt   <= CNT_W'(FLUSH_CYCLES - 1);
            r_state <= S_FLUSH;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_FLUSH: begin
          if (r_cnt == '0) begin
            r_flush <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // In IDLE the hold simply mirrors the RS entry valid; reset forces a release
  assign busy_branch = ~rst & ((r_state == S_IDLE) ? busy_in : (r_state != S_DONE));
  assign jump_en     = r_jump_en;
  assign jump_addr   = r_jump_addr;
  assign flush       = r_flush;
  assign link_en     = r_link_en;
  assign link_data   = r_link_data;
  assign misalign    = r_misalign;

endmodule

// File: tb/tb_ex_branch.sv
// tb/tb_ex_branch.sv - directed vector bench for ex_branch
module tb_ex_branch;
  import ex_branch_pkg::*;

  localparam int FC = 2;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] pc;
  logic [31:0] offset;
  logic        busy_in;
  logic [5:0]  op;
  logic [4:0]  tagx;
  logic [4:0]  tagy;
  logic [31:0] datax;
  logic [31:0] datay;
  logic        busy_branch;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        flush;
  logic        link_en;
  logic [31:0] link_data;
  logic        misalign;

  int checks;
  int failures;

  ex_branch #(.FLUSH_CYCLES(FC)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .pc          (pc),
    .offset      (offset),
    .busy_in     (busy_in),
    .op          (op),
    .tagx        (tagx),
    .tagy        (tagy),
    .datax       (datax),
    .datay       (datay),
    .busy_branch (busy_branch),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .flush       (flush),
    .link_en     (link_en),
    .link_data   (link_data),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] off;
    logic [31:0] dx;
    logic [31:0] dy;
    logic        taken;
    logic [31:0] addr;
    logic        lnk;
    logic [31:0] link;
    logic        mis;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic present(input logic [5:0] o, input logic [31:0] p, input logic [31:0] f,
                         input logic [31:0] x, input logic [31:0] y);
    op = o; pc = p; offset = f; datax = x; datay = y;
    busy_in = 1'b1; tagx = 5'd0; tagy = 5'd0;
  endtask

  task automatic wait_release(input string nm);
    for (int i = 0; i < 12; i++) begin
      if (busy_branch == 1'b0) break;
      @(negedge clk);
    end
    chk(nm, busy_branch, 1'b0);
  endtask

  initial begin
    int seen;
    checks = 0; failures = 0;
    rst = 1'b1; rdy = 1'b1; busy_in = 1'b0; op = '0; pc = '0; offset = '0;
    tagx = '0; tagy = '0; datax = '0; datay = '0;

    vecs[0] = '{OP_BEQ,  32'h100,      32'h20,       32'h5,        32'h5,        1'b1, 32'h120,  1'b0, 32'h104,  1'b0};
    vecs[1] = '{OP_BLT,  32'h300,      32'h40,       32'hFFFFFFFF, 32'h1,        1'b1, 32'h340,  1'b0, 32'h304,  1'b0};
    vecs[2] = '{OP_BLTU, 32'h300,      32'h40,       32'hFFFFFFFF, 32'h1,        1'b0, 32'h340,  1'b0, 32'h304,  1'b0};
    vecs[3] = '{OP_JALR, 32'h200,      32'h0,        32'h1003,     32'h0,        1'b1, 32'h1002, 1'b1, 32'h204,  1'b1};
    vecs[4] = '{OP_JAL,  32'hFFFFFFFC, 32'h8,        32'h0,        32'h0,        1'b1, 32'h4,    1'b1, 32'h0,    1'b0};
    vecs[5] = '{OP_BNE,  32'h400,      32'h10,       32'h3,        32'h3,        1'b0, 32'h410,  1'b0, 32'h404,  1'b0};
    vecs[6] = '{OP_BGE,  32'h500,      32'hFFFFFFF0, 32'h1,        32'hFFFFFFFF, 1'b1, 32'h4F0,  1'b0, 32'h504,  1'b0};
    vecs[7] = '{OP_BGEU, 32'h500,      32'hFFFFFFF0, 32'h1,        32'hFFFFFFFF, 1'b0, 32'h4F0,  1'b0, 32'h504,  1'b0};
    vecs[8] = '{OP_BEQ,  32'h600,      32'h6,        32'h0,        32'h0,        1'b1, 32'h606,  1'b0, 32'h604,  1'b1};
    vecs[9] = '{6'h3F,   32'h700,      32'h8,        32'h1,        32'h1,        1'b0, 32'h708,  1'b0, 32'h704,  1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy_branch", busy_branch, 1'b0);
    chk("rst_jump_en", jump_en, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_link_en", link_en, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_jump_addr", jump_addr, 32'h0);
    chk("rst_link_data", link_data, 32'h0);
    rst = 1'b0;

    // Table vectors, issued back to back
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      present(vecs[i].op, vecs[i].pc, vecs[i].off, vecs[i].dx, vecs[i].dy);
      @(posedge clk);
      @(negedge clk);
      busy_in = 1'b0;
      chk($sformatf("v%0d_exec_jump_en", i), jump_en, 1'b0);
      chk($sformatf("v%0d_exec_busy", i), busy_branch, 1'b1);
      @(negedge clk);
      chk($sformatf("v%0d_jump_en", i), jump_en, vecs[i].taken);
      chk($sformatf("v%0d_jump_addr", i), jump_addr, vecs[i].addr);
      chk($sformatf("v%0d_link_en", i), link_en, vecs[i].lnk);
      chk($sformatf("v%0d_link_data", i), link_data, vecs[i].link);
      chk($sformatf("v%0d_misalign", i), misalign, vecs[i].mis);
      chk($sformatf("v%0d_resp_flush", i), flush, 1'b0);
      chk($sformatf("v%0d_resp_busy", i), busy_branch, 1'b1);
      if (vecs[i].taken) begin
        for (int k = 0; k < FC; k++) begin
          @(negedge clk);
          chk($sformatf("v%0d_flush_c%0d", i, k), flush, 1'b1);
          chk($sformatf("v%0d_flush_busy_c%0d", i, k), busy_branch, 1'b1);
          chk($sformatf("v%0d_flush_jump_en_c%0d", i, k), jump_en, 1'b0);
        end
      end
      @(negedge clk);
      chk($sformatf("v%0d_release", i), busy_branch, 1'b0);
      chk($sformatf("v%0d_done_flush", i), flush, 1'b0);
    end

    // Operand tag locked for 4 cycles: must wait in IDLE holding the entry
    @(negedge clk);
    present(OP_BEQ, 32'h900, 32'h8, 32'h7, 32'h7);
    tagx = 5'd9;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("lock_busy_c%0d", c), busy_branch, 1'b1);
      chk($sformatf("lock_jump_en_c%0d", c), jump_en, 1'b0);
    end
    tagx = 5'd0;
    @(posedge clk);
    @(negedge clk);
    busy_in = 1'b0;
    chk("lock_exec_jump_en", jump_en, 1'b0);
    @(negedge clk);
    chk("lock_jump_en", jump_en, 1'b1);
    chk("lock_jump_addr", jump_addr, 32'h908);
    wait_release("lock_release");

    // rdy low during RESP freezes the pulse and the FSM
    @(negedge clk);
    present(OP_BEQ, 32'h800, 32'h10, 32'h2, 32'h2);
    @(posedge clk);
    @(negedge clk);
    busy_in = 1'b0;
    @(negedge clk);
    chk("rdy_resp_jump_en", jump_en, 1'b1);
    rdy = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rdy_hold_jump_en", jump_en, 1'b1);
      chk("rdy_hold_flush", flush, 1'b0);
      chk("rdy_hold_addr", jump_addr, 32'h810);
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("rdy_resume_jump_en", jump_en, 1'b0);
    chk("rdy_resume_flush", flush, 1'b1);
    wait_release("rdy_release");

    // Reset asserted in the middle of the flush window
    @(negedge clk);
    present(OP_JAL, 32'hA00, 32'h40, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    busy_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_flush_flush", flush, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_flush", flush, 1'b0);
    chk("mid_rst_busy", busy_branch, 1'b0);
    chk("mid_rst_link_en", link_en, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (jump_en || flush) seen++;
    end
    chk("post_rst_no_redirect", seen, 0);
    chk("post_rst_busy", busy_branch, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
